seven_seg_scanner: RTL and testbench

Output-side counterpart to the switch input-conditioning flops: drives the board's 4-digit, common-anode seven-segment display from an internal 16-bit hex value. Time-multiplexes the digits using a refresh prescaler, inserts a blanking gap at each digit change to suppress ghosting, and double-buffers the displayed value so updates land only on frame boundaries (no tearing). Sits between core logic and the top-level `an`/`seg`/`dp` pins.

---
 rtl/seven_seg_pkg.sv | 45 ++++
 rtl/seven_seg_scanner_decoder.sv | 16 +
 rtl/seven_seg_scanner.sv | 107 ++++++++++
 tb/tb_seven_seg_scanner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, buffer type and hex glyph table for the seven-segment scanner.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;

    // Active-low "everything dark" patterns for the display pins
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;
    localparam logic [SEG_W-1:0]      SEG_OFF = '1;
    localparam logic                  DP_OFF  = 1'b1;

    // One display image: four nibbles, per-digit decimal point and enable
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   digit_en;
    } disp_buf_t;

    // Hex nibble to active-low segment pattern, bit 0 = a ... bit 6 = g
    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        logic [SEG_W-1:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// Combinational hex-nibble to active-low seven-segment pattern decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    // Table lookup shared with anything else that needs the glyph set
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Scans a 4-digit common-anode display with per-slot blanking and frame-synchronous updates.
// Latency: pins are registered, 1 cycle behind count/idx/active image; load visible within one frame + 1 cycle.
// Backpressure: none; load is always accepted (last write before a frame boundary wins).
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int PRESCALE = 100000,
    parameter int BLANK    = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int              CW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   LAST    = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]   BLANK_C = CW'(BLANK);

    logic [CW-1:0]    count;
    logic [1:0]       idx;
    logic             slot_end;
    logic             boundary;
    disp_buf_t        pend;
    disp_buf_t        act;
    logic             pend_valid;
    disp_buf_t        load_buf;
    logic [3:0]       nibble;
    logic [SEG_W-1:0] dec_seg;
    logic             lit;

    assign slot_end = (count == LAST);
    assign boundary = slot_end && (idx == 2'd3);
    assign load_buf = {value, dp, digit_en};

    // Prescaler: count cycles within a slot, advance the digit index at slot end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            idx   <= '0;
        end else begin
            count <= slot_end ? '0 : count + 1'b1;
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Double buffer: park loads in pending, promote to active only on the frame boundary;
    // a load landing exactly on the boundary goes straight to active and supersedes pending
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend       <= '0;
            act        <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            pend_valid <= 1'b0;
            if (load) begin
                act <= load_buf;
            end else if (pend_valid) begin
                act <= pend;
            end
        end else if (load) begin
            pend       <= load_buf;
            pend_valid <= 1'b1;
        end
    end

    // Select the nibble for the digit currently being scanned
    always_comb begin
        nibble = act.value[{idx, 2'b00} +: 4];
        lit    = (count >= BLANK_C) && act.digit_en[idx];
    end

    seg_decoder u_seg_decoder (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // Pin registers: dark during the blanking gap or for disabled digits, else one anode low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp_n       <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (lit) begin
                an   <= ~(4'b0001 << idx);
                seg  <= dec_seg;
                dp_n <= ~act.dp[idx];
            end else begin
                an   <= AN_OFF;
                seg  <= SEG_OFF;
                dp_n <= DP_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with PRESCALE=8, BLANK=2 (32-cycle frames).
// Latency: expectations are keyed by the state cycle that drove the registered pins.
// Backpressure: n/a.
module tb_seven_seg_scanner;

    logic        clock;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_done;

    seven_seg_scanner #(.PRESCALE(8), .BLANK(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // State cycle index since reset release: state n lies between posedge n and posedge n+1
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic push_dark(input int from, input int to);
        exp_t e;
        for (int n = from; n <= to; n++) begin
            e.n = n; e.an = 4'b1111; e.seg = 7'b1111111; e.dpn = 1'b1;
            e.fd = (n % 32 == 31);
            q.push_back(e);
        end
    endtask

    // One frame starting at fs; seg/dp_n per digit are hand-entered glyphs
    task automatic push_frame(input int fs, input int last,
                              input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpn, input logic [3:0] en);
        exp_t       e;
        logic [6:0] s[4];
        int         slot;
        int         c;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int n = fs; n < fs + 32 && n <= last; n++) begin
            slot = (n - fs) / 8;
            c    = (n - fs) % 8;
            e.n  = n;
            e.fd = (n % 32 == 31);
            if (c < 2 || !en[slot]) begin
                e.an = 4'b1111; e.seg = 7'b1111111; e.dpn = 1'b1;
            end else begin
                e.an = 4'b1111; e.an[slot] = 1'b0;
                e.seg = s[slot]; e.dpn = dpn[slot];
            end
            q.push_back(e);
        end
    endtask

    task automatic load_at(input int n, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        tests++;
        if (cyc > n) begin
            fails++;
            $display("FAIL load_sched: at state %0d, required <= %0d", cyc, n);
        end
        while (cyc < n) @(negedge clock);
        value = v; dp = d; digit_en = e; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic check_off(input string name);
        tests++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp_n !== 1'b1 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL %s: an=%b seg=%b dp_n=%b fd=%b, required an=1111 seg=1111111 dp_n=1 fd=0",
                     name, an, seg, dp_n, frame_done);
        end
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expectations left, required 0 (next n=%0d)", name, q.size(), q[0].n);
        end
    endtask

    // Monitor: every cycle check the anode invariant and retire any expectation due now
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge clock);
            if (!reset && cyc >= 1) begin
                n = cyc - 1;
                tests++;
                if ($countones(~an) > 1) begin
                    fails++;
                    $display("FAIL anode_onehot n=%0d: an=%b, required at most one low", n, an);
                end
                while (q.size() > 0 && q[0].n < n) begin
                    e = q.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL missed_check: expectation n=%0d not reached, now n=%0d", e.n, n);
                end
                if (q.size() > 0 && q[0].n == n) begin
                    e = q.pop_front();
                    tests++;
                    if (an !== e.an || seg !== e.seg || dp_n !== e.dpn || frame_done !== e.fd) begin
                        fails++;
                        $display("FAIL pins n=%0d: an=%b seg=%b dp_n=%b fd=%b, required an=%b seg=%b dp_n=%b fd=%b",
                                 n, an, seg, dp_n, frame_done, e.an, e.seg, e.dpn, e.fd);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; load = 1'b0; value = '0; dp = '0; digit_en = '0;
        repeat (3) @(negedge clock);
        check_off("reset_state");
        reset = 1'b0;

        // Dark until the first commit at state 31
        push_dark(0, 31);
        // 1A80, dp on digit 0
        push_frame(32, 63, 7'b1000000, 7'b0000000, 7'b0001000, 7'b1111001, 4'b1110, 4'b1111);
        // 0000 then FFFF mid-frame: only F shows
        push_frame(64, 95, 7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110, 4'b1111, 4'b1111);
        // 2C9D loaded on boundary 95 overrides pending 7777, twice (pending discarded)
        push_frame(96, 127, 7'b0100001, 7'b0010000, 7'b1000110, 7'b0100100, 4'b0101, 4'b1111);
        push_frame(128, 159, 7'b0100001, 7'b0010000, 7'b1000110, 7'b0100100, 4'b0101, 4'b1111);
        // 4321 with digits 1 and 3 disabled, partial frame before the reset
        push_frame(160, 179, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 4'b0000, 4'b0101);

        load_at(3,   16'h1A80, 4'b0001, 4'b1111);
        load_at(40,  16'h0000, 4'b0000, 4'b1111);
        load_at(50,  16'hFFFF, 4'b0000, 4'b1111);
        load_at(80,  16'h7777, 4'b0000, 4'b1111);
        load_at(95,  16'h2C9D, 4'b1010, 4'b1111);
        load_at(130, 16'h4321, 4'b1111, 4'b0101);
        load_at(178, 16'h8888, 4'b1111, 4'b1111);

        while (cyc < 181) @(negedge clock);
        check_drained("phase_a_drained");
        #2 reset = 1'b1;
        #1 check_off("async_reset_off");
        repeat (3) @(negedge clock);
        check_off("reset_hold");
        reset = 1'b0;

        // Pending 8888 must be gone: dark until 6B0E commits at state 63
        push_dark(0, 63);
        push_frame(64, 95, 7'b0000110, 7'b1000000, 7'b0000011, 7'b0000010, 4'b1011, 4'b1111);
        load_at(45, 16'h6B0E, 4'b0100, 4'b1111);

        while (cyc < 97) @(negedge clock);
        #1 check_drained("phase_b_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
